// File: rtl/cpx_spc_ibuf_pkg.sv
// CPX return-packet definitions shared by the SPARC core input buffer.
// Field positions mirror the iop.h CPX layout.
package cpx_spc_ibuf_pkg;

    localparam int CPX_WIDTH = 145;
    localparam int CPX_VLD   = 144;
    localparam int CPX_ATOM  = 129;

    typedef logic [CPX_WIDTH-1:0] cpx_pkt_t;

    typedef enum logic {
        ISSUE = 1'b0,
        ATOM2 = 1'b1
    } ibuf_st_e;

    function automatic logic is_atom(cpx_pkt_t p);
        return p[CPX_VLD] & p[CPX_ATOM];
    endfunction

endpackage

// File: rtl/cpx_spc_ibuf_if.sv
// Upstream NoC-decoder to CPX input buffer packet handshake.
// The buffer side is the slave; the decoder side is the master.
interface cpx_spc_ibuf_if;
    import cpx_spc_ibuf_pkg::*;

    logic     pkt_in_val;
    cpx_pkt_t pkt_in_data;
    logic     pkt_in_rdy;

    modport master (
        output pkt_in_val,
        output pkt_in_data,
        input  pkt_in_rdy
    );

    modport slave (
        input  pkt_in_val,
        input  pkt_in_data,
        output pkt_in_rdy
    );

endinterface

// File: rtl/cpx_spc_ibuf_fifo.sv
// Circular packet store for the CPX input buffer.
// Reports the head entry, whether a second entry exists, and occupancy.
module cpx_ibuf_fifo
    import cpx_spc_ibuf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          rclk,
    input  logic          reset,
    input  logic          push,
    input  cpx_pkt_t      push_data,
    input  logic          pop,
    output cpx_pkt_t      head,
    output logic          head_nxt_vld,
    output logic [CW-1:0] count
);

    cpx_pkt_t        mem [DEPTH];
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   wptr;
    logic [CW-1:0]   push_inc;
    logic [CW-1:0]   pop_dec;

    assign push_inc = {{AW{1'b0}}, push};
    assign pop_dec  = {{AW{1'b0}}, pop};

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + push_inc - pop_dec;
        end
    end

    // Payload storage carries no reset; occupancy gates every read.
    always_ff @(posedge rclk) begin
        if (push) mem[wptr] <= push_data;
    end

    assign head         = mem[rptr];
    assign head_nxt_vld = (count > CW'(1));

endmodule

// File: rtl/cpx_spc_ibuf.sv
// CPX-to-SPARC input buffer: queues return packets and issues them
// to the core one per cycle, keeping atomic halves back to back.
module cpx_spc_ibuf
    import cpx_spc_ibuf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          rclk,
    input  logic          reset,
    cpx_spc_ibuf_if.slave pkt,
    output cpx_pkt_t      cpx_spc_data_cx2,
    output logic          cpx_spc_data_rdy_cx2,
    output logic [CW-1:0] ibuf_count
);

    ibuf_st_e state;
    ibuf_st_e state_nxt;
    cpx_pkt_t head;
    logic     head_nxt_vld;
    logic     push;
    logic     pop;
    logic     have_head;

    assign pkt.pkt_in_rdy = (ibuf_count < CW'(DEPTH));
    assign push           = pkt.pkt_in_val & pkt.pkt_in_rdy;
    assign have_head      = (ibuf_count != '0);

    cpx_ibuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .rclk         (rclk),
        .reset        (reset),
        .push         (push),
        .push_data    (pkt.pkt_in_data),
        .pop          (pop),
        .head         (head),
        .head_nxt_vld (head_nxt_vld),
        .count        (ibuf_count)
    );

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) state <= ISSUE;
        else       state <= state_nxt;
    end

    // An atomic head waits until its partner is queued behind it.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (1'b1)
            (state == ATOM2): begin
                pop       = 1'b1;
                state_nxt = ISSUE;
            end
            (state == ISSUE): begin
                if (have_head && !is_atom(head)) begin
                    pop = 1'b1;
                end else if (have_head && head_nxt_vld) begin
                    pop       = 1'b1;
                    state_nxt = ATOM2;
                end
            end
        endcase
    end

    // Issue decodes only flopped state, so no input reaches the core directly.
    assign cpx_spc_data_rdy_cx2 = pop;
    assign cpx_spc_data_cx2     = pop ? head : '0;

endmodule
